// File: rtl/rampa_angulos_if.sv
// Target-pose handshake between the sequence source and the angle ramp.
interface rampa_angulos_if;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [23:0] tgt_ang;
    logic [7:0]  tgt_hold;

    modport master (output tgt_valid, tgt_ang, tgt_hold, input tgt_ready);
    modport slave  (input tgt_valid, tgt_ang, tgt_hold, output tgt_ready);
endinterface

// File: rtl/rampa_angulos.sv
// Slews three servo angles toward a target pose once per PWM frame, then holds the pose.
// Define RAMPA_BYPASS_EN to load targets directly and skip the ramp.
//
// state | meaning
// IDLE  | ready for a new pose, outputs hold the last pose
// RAMP  | stepping each channel toward its target on every frame tick
// HOLD  | pose reached, counting down hold frames
module rampa_angulos #(
    parameter int FRAME_CYC = 1000000,
    parameter int STEP      = 1,
    parameter int ANG_MAX   = 180,
    parameter int HOME      = 90
) (
    input  logic             CLK,
    input  logic             RST_N,
    rampa_angulos_if.slave   tgt,
    output logic [7:0]       ang1,
    output logic [7:0]       ang2,
    output logic [7:0]       ang3,
    output logic             busy,
    output logic             done
);
    localparam logic [19:0] FRAME_LAST = 20'(FRAME_CYC - 1);
    localparam logic [8:0]  STEP9      = 9'(STEP);
    localparam logic [7:0]  ANG_MAX8   = 8'(ANG_MAX);
    localparam logic [7:0]  HOME8      = 8'(HOME);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} stateT;

    stateT       state;
    logic [19:0] frameCnt;
    logic        tick;
    logic [7:0]  holdCnt;
    logic [7:0]  tgtHold;
    logic [7:0]  tgt1, tgt2, tgt3;
    logic [7:0]  nxt1, nxt2, nxt3;
    logic        reached;

    function automatic logic [7:0] clampAng(input logic [7:0] a);
        return (a > ANG_MAX8) ? ANG_MAX8 : a;
    endfunction

    // 9-bit distance so cur +/- STEP can never wrap past 0 or 255.
    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] dst);
        logic [8:0] diff;
        if (dst >= cur) diff = {1'b0, dst} - {1'b0, cur};
        else            diff = {1'b0, cur} - {1'b0, dst};
        if (diff <= STEP9)   return dst;
        else if (dst > cur)  return 8'({1'b0, cur} + STEP9);
        else                 return 8'({1'b0, cur} - STEP9);
    endfunction

    assign tick          = (frameCnt == FRAME_LAST);
    assign tgt.tgt_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    always_comb begin
        nxt1    = slew(ang1, tgt1);
        nxt2    = slew(ang2, tgt2);
        nxt3    = slew(ang3, tgt3);
        reached = (nxt1 == tgt1) && (nxt2 == tgt2) && (nxt3 == tgt3);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            frameCnt <= '0;
            holdCnt  <= '0;
            tgtHold  <= '0;
            tgt1     <= HOME8;
            tgt2     <= HOME8;
            tgt3     <= HOME8;
            ang1     <= HOME8;
            ang2     <= HOME8;
            ang3     <= HOME8;
            done     <= 1'b0;
        end else begin
            frameCnt <= tick ? '0 : frameCnt + 20'd1;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt.tgt_valid) begin
                        tgt1    <= clampAng(tgt.tgt_ang[23:16]);
                        tgt2    <= clampAng(tgt.tgt_ang[15:8]);
                        tgt3    <= clampAng(tgt.tgt_ang[7:0]);
                        tgtHold <= tgt.tgt_hold;
`ifdef RAMPA_BYPASS_EN
                        ang1    <= clampAng(tgt.tgt_ang[23:16]);
                        ang2    <= clampAng(tgt.tgt_ang[15:8]);
                        ang3    <= clampAng(tgt.tgt_ang[7:0]);
                        holdCnt <= tgt.tgt_hold;
                        state   <= HOLD;
`else
                        state   <= RAMP;
`endif
                    end
                end
                RAMP: begin
                    if (tick) begin
                        ang1 <= nxt1;
                        ang2 <= nxt2;
                        ang3 <= nxt3;
                        if (reached) begin
                            holdCnt <= tgtHold;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (holdCnt == 8'd0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            holdCnt <= holdCnt - 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rampa_angulos.sv
// Directed checks of rampa_angulos with a 10-cycle frame: one instance at STEP=1, one at STEP=4.
module tb_rampa_angulos;
    logic CLK;
    logic RST_N;
    int   edgeCnt;
    int   checks;
    int   errors;

    rampa_angulos_if if1 ();
    rampa_angulos_if if4 ();

    logic [7:0] d1Ang1, d1Ang2, d1Ang3, d4Ang1, d4Ang2, d4Ang3;
    logic       d1Busy, d1Done, d4Busy, d4Done;

    rampa_angulos #(.FRAME_CYC(10), .STEP(1), .ANG_MAX(180), .HOME(90)) d1 (
        .CLK(CLK), .RST_N(RST_N), .tgt(if1.slave),
        .ang1(d1Ang1), .ang2(d1Ang2), .ang3(d1Ang3), .busy(d1Busy), .done(d1Done)
    );

    rampa_angulos #(.FRAME_CYC(10), .STEP(4), .ANG_MAX(180), .HOME(90)) d4 (
        .CLK(CLK), .RST_N(RST_N), .tgt(if4.slave),
        .ang1(d4Ang1), .ang2(d4Ang2), .ang3(d4Ang3), .busy(d4Busy), .done(d4Done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Edge number since reset release; frame ticks fall on edges 10, 20, 30, ...
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) edgeCnt <= 0;
        else        edgeCnt <= edgeCnt + 1;
    end

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic goEdge(input int target);
        while (edgeCnt < target) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send1(input int a1, input int a2, input int a3, input int hold);
        if1.tgt_valid = 1'b1;
        if1.tgt_ang   = {8'(a1), 8'(a2), 8'(a3)};
        if1.tgt_hold  = 8'(hold);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST_N  = 1'b0;
        if1.tgt_valid = 1'b0; if1.tgt_ang = '0; if1.tgt_hold = '0;
        if4.tgt_valid = 1'b0; if4.tgt_ang = '0; if4.tgt_hold = '0;

        #12;
        checkVal("rst_ang1", int'(d1Ang1), 90);
        checkVal("rst_ang2", int'(d1Ang2), 90);
        checkVal("rst_ang3", int'(d1Ang3), 90);
        checkVal("rst_busy", int'(d1Busy), 0);
        checkVal("rst_done", int'(d1Done), 0);
        checkVal("rst_d4ang1", int'(d4Ang1), 90);
        @(negedge CLK);
        RST_N = 1'b1;
        goEdge(1);
        checkVal("rel_ready", int'(if1.tgt_ready), 1);

`ifdef RAMPA_BYPASS_EN
        send1(10, 20, 30, 0);
        if4.tgt_valid = 1'b1; if4.tgt_ang = {8'd200, 8'd5, 8'd7}; if4.tgt_hold = 8'd0;
        goEdge(2);
        if1.tgt_valid = 1'b0;
        if4.tgt_valid = 1'b0;
        checkVal("byp_ang1", int'(d1Ang1), 10);
        checkVal("byp_ang2", int'(d1Ang2), 20);
        checkVal("byp_ang3", int'(d1Ang3), 30);
        checkVal("byp_busy", int'(d1Busy), 1);
        checkVal("byp_clamp1", int'(d4Ang1), 180);
        checkVal("byp_clamp2", int'(d4Ang2), 5);
        goEdge(9);
        checkVal("byp_done_early", int'(d1Done), 0);
        goEdge(10);
        checkVal("byp_done", int'(d1Done), 1);
        checkVal("byp_ready", int'(if1.tgt_ready), 1);
`else
        // Basic ramp (100,80,90), hold 0, transfer on edge 2.
        send1(100, 80, 90, 0);
        goEdge(2);
        if1.tgt_valid = 1'b0;
        checkVal("xfer_busy", int'(d1Busy), 1);
        checkVal("xfer_ready", int'(if1.tgt_ready), 0);
        goEdge(9);
        checkVal("pre_tick_ang1", int'(d1Ang1), 90);
        goEdge(10);
        checkVal("t1_ang1", int'(d1Ang1), 91);
        checkVal("t1_ang2", int'(d1Ang2), 89);
        checkVal("t1_ang3", int'(d1Ang3), 90);
        goEdge(50);
        checkVal("t5_ang1", int'(d1Ang1), 95);
        checkVal("t5_ang2", int'(d1Ang2), 85);

        // Back-pressure: new pose offered mid-ramp is held off until IDLE.
        send1(102, 80, 90, 0);
        goEdge(51);
        checkVal("bp_ready", int'(if1.tgt_ready), 0);
        goEdge(100);
        checkVal("t10_ang1", int'(d1Ang1), 100);
        checkVal("t10_ang2", int'(d1Ang2), 80);
        checkVal("t10_ang3", int'(d1Ang3), 90);
        checkVal("t10_busy", int'(d1Busy), 1);
        goEdge(109);
        checkVal("done_early", int'(d1Done), 0);
        goEdge(110);
        checkVal("done_pulse", int'(d1Done), 1);
        checkVal("done_ready", int'(if1.tgt_ready), 1);
        checkVal("done_busy", int'(d1Busy), 0);
        checkVal("done_ang1", int'(d1Ang1), 100);
        goEdge(111);
        if1.tgt_valid = 1'b0;
        checkVal("done_clear", int'(d1Done), 0);
        checkVal("bp_xfer_busy", int'(d1Busy), 1);
        goEdge(120);
        checkVal("bp_ang1_t1", int'(d1Ang1), 101);
        goEdge(130);
        checkVal("bp_ang1_t2", int'(d1Ang1), 102);
        goEdge(140);
        checkVal("bp_done", int'(d1Done), 1);

        // Same pose, hold 3, transfer coincident with the tick on edge 150.
        goEdge(149);
        send1(102, 80, 90, 3);
        goEdge(150);
        if1.tgt_valid = 1'b0;
        checkVal("hold_busy", int'(d1Busy), 1);
        goEdge(160);
        checkVal("hold_ang1", int'(d1Ang1), 102);
        goEdge(199);
        checkVal("hold_done_early", int'(d1Done), 0);
        checkVal("hold_busy_late", int'(d1Busy), 1);
        goEdge(200);
        checkVal("hold_done", int'(d1Done), 1);
        goEdge(201);
        checkVal("hold_done_clear", int'(d1Done), 0);

        // Clamp and STEP=4: (200,0,180) -> 180/0/180 in 23 ticks.
        goEdge(210);
        if4.tgt_valid = 1'b1; if4.tgt_ang = {8'd200, 8'd0, 8'd180}; if4.tgt_hold = 8'd0;
        goEdge(211);
        if4.tgt_valid = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            int e1, e2;
            goEdge(210 + 10 * k);
            e1 = (90 + 4 * k > 180) ? 180 : 90 + 4 * k;
            e2 = (90 - 4 * k < 0) ? 0 : 90 - 4 * k;
            checkVal($sformatf("s4_ang1_t%0d", k), int'(d4Ang1), e1);
            checkVal($sformatf("s4_ang2_t%0d", k), int'(d4Ang2), e2);
            checkVal($sformatf("s4_ang3_t%0d", k), int'(d4Ang3), e1);
        end
        checkVal("s4_busy", int'(d4Busy), 1);
        goEdge(449);
        checkVal("s4_done_early", int'(d4Done), 0);
        goEdge(450);
        checkVal("s4_done", int'(d4Done), 1);

        // Reset mid-ramp while ang1 descends through 95.
        goEdge(460);
        send1(80, 80, 90, 0);
        goEdge(461);
        if1.tgt_valid = 1'b0;
        goEdge(530);
        checkVal("mid_ang1", int'(d1Ang1), 95);
        #2;
        RST_N = 1'b0;
        #1;
        checkVal("mid_rst_ang1", int'(d1Ang1), 90);
        checkVal("mid_rst_ang2", int'(d1Ang2), 90);
        checkVal("mid_rst_busy", int'(d1Busy), 0);
        checkVal("mid_rst_d4ang1", int'(d4Ang1), 90);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        goEdge(1);
        checkVal("mid_rel_ready", int'(if1.tgt_ready), 1);
        goEdge(25);
        checkVal("mid_discard_ang1", int'(d1Ang1), 90);
        checkVal("mid_discard_busy", int'(d1Busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
